// File: rtl/jamma_joy_scan_if.sv
// Pin-side bundle for the JAMMA joystick scanner.
//   scan_en    : 1 = scanning runs, 0 = scanner frozen
//   jjoy       : shared JAMMA joystick bus, active-low
//   joy_local  : on-board joystick, active-low, merged into player 1 only
//   joy_select : JSELECT drive, 0 = player 1 on jjoy, 1 = player 2
//   joy1/joy2  : debounced active-low player words
//   scan_done  : high during the player-2 sample cycle
// master = core/board side, slave = scanner.
interface jamma_joy_scan_if;
    logic       scan_en;
    logic [7:0] jjoy;
    logic [5:0] joy_local;
    logic       joy_select;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       scan_done;

    modport master (
        output scan_en, jjoy, joy_local,
        input  joy_select, joy1, joy2, scan_done
    );

    modport slave (
        input  scan_en, jjoy, joy_local,
        output joy_select, joy1, joy2, scan_done
    );
endinterface

// File: rtl/jamma_joy_scan.sv
// Time-multiplexed JAMMA joystick scanner. Drives JSELECT, waits
// SETTLE_CYCLES after each select change, samples the shared jjoy bus for
// each player and debounces every bit independently.
//   pclk  : core pixel clock, rising edge
//   reset : asynchronous, active-high
//   bus   : jamma_joy_scan_if.slave (scan_en, jjoy, joy_local in;
//           joy_select, joy1, joy2, scan_done out)
module jamma_joy_scan #(
    parameter int unsigned SETTLE_CYCLES    = 4,
    parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
    input  logic               pclk,
    input  logic               reset,
    jamma_joy_scan_if.slave    bus
);

    localparam logic [1:0] ST_SETTLE1 = 2'd0;
    localparam logic [1:0] ST_SAMPLE1 = 2'd1;
    localparam logic [1:0] ST_SETTLE2 = 2'd2;
    localparam logic [1:0] ST_SAMPLE2 = 2'd3;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] DEB_LAST    = 3'(DEBOUNCE_SAMPLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic [7:0] joy1_q, joy1_d;
    logic [7:0] joy2_q, joy2_d;
    logic [2:0] deb1_q [8];
    logic [2:0] deb1_d [8];
    logic [2:0] deb2_q [8];
    logic [2:0] deb2_d [8];

    logic [7:0] sample;
    logic       apply1;
    logic       apply2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        deb1_d  = deb1_q;
        deb2_d  = deb2_q;
        sample  = '1;
        apply1  = 1'b0;
        apply2  = 1'b0;

        if (bus.scan_en) begin
            case (state_q)
                ST_SETTLE1, ST_SETTLE2: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = (state_q == ST_SETTLE1) ? ST_SAMPLE1 : ST_SAMPLE2;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SAMPLE1: begin
                    sample  = bus.jjoy & {2'b11, bus.joy_local};
                    apply1  = 1'b1;
                    sel_d   = 1'b1;
                    state_d = ST_SETTLE2;
                end
                default: begin
                    sample  = bus.jjoy;
                    apply2  = 1'b1;
                    sel_d   = 1'b0;
                    state_d = ST_SETTLE1;
                end
            endcase
        end

        // A bit flips only after DEBOUNCE_SAMPLES consecutive disagreeing
        // scans; any agreeing scan restarts its count.
        if (apply1) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (sample[b] == joy1_q[b]) begin
                    deb1_d[b] = '0;
                end else if (deb1_q[b] == DEB_LAST) begin
                    joy1_d[b] = sample[b];
                    deb1_d[b] = '0;
                end else begin
                    deb1_d[b] = deb1_q[b] + 3'd1;
                end
            end
        end

        if (apply2) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (sample[b] == joy2_q[b]) begin
                    deb2_d[b] = '0;
                end else if (deb2_q[b] == DEB_LAST) begin
                    joy2_d[b] = sample[b];
                    deb2_d[b] = '0;
                end else begin
                    deb2_d[b] = deb2_q[b] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SETTLE1;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            joy1_q  <= '1;
            joy2_q  <= '1;
            deb1_q  <= '{default: '0};
            deb2_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            deb1_q  <= deb1_d;
            deb2_q  <= deb2_d;
        end
    end

    assign bus.joy_select = sel_q;
    assign bus.joy1       = joy1_q;
    assign bus.joy2       = joy2_q;
    // Combinational so it is high for the whole SAMPLE2 cycle and drops
    // immediately when scanning is paused.
    assign bus.scan_done  = bus.scan_en && (state_q == ST_SAMPLE2);

endmodule

// File: tb/tb_jamma_joy_scan.sv
// Directed self-checking bench for jamma_joy_scan with default parameters
// (scan period 10 cycles: select rises after cycle 5, scan_done in cycle 9).
module tb_jamma_joy_scan;

    logic pclk;
    logic reset;
    jamma_joy_scan_if bus ();

    jamma_joy_scan #(
        .SETTLE_CYCLES    (4),
        .DEBOUNCE_SAMPLES (3)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] p1 = 8'hFF;
    logic [7:0] p2 = 8'hFF;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Present the word for whichever player the select model says is routed.
    task automatic drive();
        bus.jjoy = ((cyc % 10) >= 5) ? p2 : p1;
    endtask

    // Advance n enabled cycles, checking select and scan_done against the
    // free-running scan timeline.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            cyc++;
            check("joy_select", 32'(bus.joy_select), 32'((cyc % 10) >= 5));
            check("scan_done", 32'(bus.scan_done), 32'((cyc % 10) == 9));
            drive();
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.scan_en   = 1'b1;
        bus.jjoy      = 8'hFF;
        bus.joy_local = 6'h3F;
        repeat (2) @(posedge pclk);
        #1;
        check("rst_sel", 32'(bus.joy_select), 32'd0);
        check("rst_joy1", 32'(bus.joy1), 32'hFF);
        check("rst_joy2", 32'(bus.joy2), 32'hFF);
        check("rst_done", 32'(bus.scan_done), 32'd0);
        @(negedge pclk);
        reset = 1'b0;
        cyc = 0;
        drive();

        // Idle scanning.
        run(30);
        check("idle_joy1", 32'(bus.joy1), 32'hFF);
        check("idle_joy2", 32'(bus.joy2), 32'hFF);

        // Player-1 bit 0 low for three scans (samples at 35, 45, 55).
        p1 = 8'hFE;
        drive();
        run(15);
        check("p1_two_scans", 32'(bus.joy1), 32'hFF);
        run(10);
        check("p1_three_scans", 32'(bus.joy1), 32'hFE);
        check("p1_joy2_clean", 32'(bus.joy2), 32'hFF);
        p1 = 8'hFF;
        drive();
        run(20);
        check("p1_release_hold", 32'(bus.joy1), 32'hFE);
        run(10);
        check("p1_release", 32'(bus.joy1), 32'hFF);

        // Player-2 bit 5 glitch for two scans (samples at 90, 100).
        p2 = 8'hDF;
        drive();
        run(10);
        check("glitch_cnt1", 32'(dut.deb2_q[5]), 32'd1);
        run(10);
        check("glitch_cnt2", 32'(dut.deb2_q[5]), 32'd2);
        check("glitch_joy2_a", 32'(bus.joy2), 32'hFF);
        p2 = 8'hFF;
        drive();
        run(10);
        check("glitch_cnt0", 32'(dut.deb2_q[5]), 32'd0);
        check("glitch_joy2_b", 32'(bus.joy2), 32'hFF);

        // Local joystick bit 2 merges into player 1 only (samples 125..145).
        bus.joy_local = 6'b111011;
        run(20);
        check("local_two", 32'(bus.joy1), 32'hFF);
        run(10);
        check("local_three", 32'(bus.joy1), 32'hFB);
        check("local_joy2", 32'(bus.joy2), 32'hFF);

        // Pause during SETTLE2 with count 2 (cycle 147).
        run(2);
        bus.scan_en = 1'b0;
        #1;
        check("pause_done_now", 32'(bus.scan_done), 32'd0);
        for (int i = 0; i < 7; i++) begin
            @(posedge pclk);
            #1;
            check("pause_sel", 32'(bus.joy_select), 32'd1);
            check("pause_done", 32'(bus.scan_done), 32'd0);
        end
        bus.scan_en = 1'b1;
        @(posedge pclk);
        #1;
        check("resume1_done", 32'(bus.scan_done), 32'd0);
        @(posedge pclk);
        #1;
        check("resume2_done", 32'(bus.scan_done), 32'd1);
        check("resume2_sel", 32'(bus.joy_select), 32'd1);
        cyc = 149;
        drive();
        run(1);

        // Drive joy1 to 7F (start pressed, local released), samples 155..175.
        bus.joy_local = 6'h3F;
        p1 = 8'h7F;
        drive();
        run(25);
        check("start_joy1", 32'(bus.joy1), 32'h7F);
        run(2);

        // Asynchronous reset mid-SETTLE2.
        #2;
        reset = 1'b1;
        #1;
        check("arst_joy1", 32'(bus.joy1), 32'hFF);
        check("arst_sel", 32'(bus.joy_select), 32'd0);
        check("arst_done", 32'(bus.scan_done), 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        reset = 1'b0;
        cyc = 0;
        p1 = 8'hFF;
        drive();
        run(10);
        check("post_rst_joy1", 32'(bus.joy1), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
